// File: rtl/seg_scan_ctrl_if.sv
// Host-side bundle for seg_scan_ctrl: value load, display attributes and scan outputs.
// Signal names carry the controller's i_/o_ point of view.
interface seg_scan_ctrl_if;
  logic [19:0] i_data;
  logic        i_data_vld;
  logic [5:0]  i_point;
  logic        i_sign;
  logic        i_seg_en;
  logic        o_busy;
  logic [5:0]  o_sel;
  logic [7:0]  o_seg;

  modport master (
    output i_data, i_data_vld, i_point, i_sign, i_seg_en,
    input  o_busy, o_sel, o_seg
  );

  modport slave (
    input  i_data, i_data_vld, i_point, i_sign, i_seg_en,
    output o_busy, o_sel, o_seg
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit LED scan controller: sequential binary-to-BCD conversion plus time-multiplexed
// sel/seg generation with leading-zero blanking, decimal points, minus sign and anti-ghost slot.
//
// state | meaning
// IDLE  | waiting for a load strobe
// SHIFT | 20 double-dabble iterations (add-3 then shift)
// DONE  | publish accumulator to the display register; chain a pending load if any
module seg_scan_ctrl #(
  parameter int unsigned SCAN_MAX  = 49_999,
  parameter int unsigned BLANK_CYC = 100
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int SLOT_W = $clog2(SCAN_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [19:0]       r_bin;
  logic [23:0]       r_bcd;
  logic [4:0]        r_bit_cnt;
  logic              r_pend;
  logic [19:0]       r_pend_val;
  logic [23:0]       r_disp_bcd;
  logic [SLOT_W-1:0] r_cnt_slot;
  logic [2:0]        r_cnt_dig;
  logic [5:0]        r_sel;
  logic [7:0]        r_seg;

  logic [19:0]       w_data_sat;
  logic [19:0]       w_load_val;
  logic              w_load;
  logic              w_shift;
  logic              w_commit;
  logic              w_pend_clr;
  logic [23:0]       w_bcd_adj;
  logic [5:0]        w_blank;
  logic [5:0]        w_minus;
  logic [5:0]        w_sel_nxt;
  logic [3:0]        w_nib;
  logic              w_dp;
  logic              w_dig_blank;
  logic              w_dig_minus;
  logic [6:0]        w_glyph;
  logic [7:0]        w_code;

  assign w_data_sat = (bus.i_data > 20'd999_999) ? 20'd999_999 : bus.i_data;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A strobe landing in DONE is folded straight into the next conversion.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = w_data_sat;
    w_shift     = 1'b0;
    w_commit    = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_data_vld) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_bit_cnt == 5'd0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_commit = 1'b1;
        if (r_pend || bus.i_data_vld) begin
          w_load      = 1'b1;
          w_load_val  = bus.i_data_vld ? w_data_sat : r_pend_val;
          w_pend_clr  = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_disp_bcd <= '0;
    end else begin
      if (w_load) begin
        r_bin     <= w_load_val;
        r_bcd     <= '0;
        r_bit_cnt <= 5'd19;
      end else if (w_shift) begin
        {r_bcd, r_bin} <= {w_bcd_adj[22:0], r_bin, 1'b0};
        if (r_bit_cnt != 5'd0) r_bit_cnt <= r_bit_cnt - 5'd1;
      end
      if (w_commit) r_disp_bcd <= r_bcd;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else if (w_pend_clr) begin
      r_pend <= 1'b0;
    end else if (bus.i_data_vld && (r_state != ST_IDLE)) begin
      r_pend     <= 1'b1;
      r_pend_val <= w_data_sat;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt_slot <= '0;
      r_cnt_dig  <= '0;
    end else if (r_cnt_slot == SLOT_W'(SCAN_MAX)) begin
      r_cnt_slot <= '0;
      r_cnt_dig  <= (r_cnt_dig == 3'd5) ? 3'd0 : r_cnt_dig + 3'd1;
    end else begin
      r_cnt_slot <= r_cnt_slot + 1'b1;
    end
  end

  // Blanking walks down from the top digit; a lit decimal point stops it.
  always_comb begin
    logic v_zero;
    v_zero  = 1'b1;
    w_blank = '0;
    for (int k = 5; k >= 1; k--) begin
      v_zero     = v_zero & (r_disp_bcd[4*k +: 4] == 4'd0) & ~bus.i_point[k];
      w_blank[k] = v_zero;
    end
  end

  assign w_minus = w_blank & ~{w_blank[4:0], 1'b0};

  always_comb begin
    w_sel_nxt   = '0;
    w_nib       = '0;
    w_dp        = 1'b0;
    w_dig_blank = 1'b0;
    w_dig_minus = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (r_cnt_dig == 3'(k)) begin
        w_sel_nxt[k] = 1'b1;
        w_nib        = r_disp_bcd[4*k +: 4];
        w_dp         = bus.i_point[k];
        w_dig_blank  = w_blank[k];
        w_dig_minus  = w_minus[k];
      end
    end
  end

  always_comb begin
    case (w_nib)
      4'd0:    w_glyph = 7'h40;
      4'd1:    w_glyph = 7'h79;
      4'd2:    w_glyph = 7'h24;
      4'd3:    w_glyph = 7'h30;
      4'd4:    w_glyph = 7'h19;
      4'd5:    w_glyph = 7'h12;
      4'd6:    w_glyph = 7'h02;
      4'd7:    w_glyph = 7'h78;
      4'd8:    w_glyph = 7'h00;
      4'd9:    w_glyph = 7'h10;
      default: w_glyph = 7'h7F;
    endcase
  end

  always_comb begin
    if (w_dig_blank) w_code = (w_dig_minus && bus.i_sign) ? 8'hBF : 8'hFF;
    else             w_code = {~w_dp, w_glyph};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel <= '0;
      r_seg <= 8'hFF;
    end else if (!bus.i_seg_en) begin
      r_sel <= '0;
      r_seg <= 8'hFF;
    end else begin
      r_sel <= w_sel_nxt;
      r_seg <= (r_cnt_slot < SLOT_W'(BLANK_CYC)) ? 8'hFF : w_code;
    end
  end

  assign bus.o_busy = (r_state != ST_IDLE);
  assign bus.o_sel  = r_sel;
  assign bus.o_seg  = r_seg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues expected display updates, a monitor
// checks busy/sel/seg every cycle against an arithmetic model of the display.
module tb_seg_scan_ctrl;
  localparam int SCAN_MAX  = 9;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = SCAN_MAX + 1;
  localparam int CONV      = 21;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.SCAN_MAX(SCAN_MAX), .BLANK_CYC(BLANK_CYC)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int start;
    int t;
    int v;
  } conv_t;

  conv_t q[$];
  int    e          = 0;
  int    cur_end    = -1000;
  bit    pend_active = 1'b0;
  int    m_disp     = 0;
  int    n_checks   = 0;
  int    n_errors   = 0;

  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic int sat(int v);
    return (v > 999_999) ? 999_999 : v;
  endfunction

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit blank_at(int v, int k, logic [5:0] pt);
    return (k > 0) && (v < pow10(k)) && ((pt >> k) == 6'd0);
  endfunction

  function automatic logic [7:0] digit_code(int v, int k, logic [5:0] pt, logic sg);
    logic [7:0] c;
    if (blank_at(v, k, pt)) begin
      c = (sg && !blank_at(v, k - 1, pt)) ? 8'hBF : 8'hFF;
    end else begin
      c = glyph[(v / pow10(k)) % 10];
      if (pt[k]) c[7] = 1'b0;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  // Conversion timing model: one engine, 21 edges per value, one pending slot (latest wins).
  task automatic model_strobe(input int n, input int v);
    while (pend_active && n > cur_end) begin
      cur_end     = cur_end + CONV;
      pend_active = 1'b0;
    end
    if (n > cur_end) begin
      cur_end = n + CONV;
      q.push_back('{n, n + CONV, sat(v)});
    end else if (pend_active) begin
      q[q.size()-1].v = sat(v);
    end else begin
      q.push_back('{cur_end, cur_end + CONV, sat(v)});
      pend_active = 1'b1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic strobe(input int v);
    bus.i_data     = v[19:0];
    bus.i_data_vld = 1'b1;
    model_strobe(e + 1, v);
    tick(1);
    bus.i_data_vld = 1'b0;
  endtask

  task automatic do_reset(input int n);
    sys_rst_n   = 1'b0;
    q.delete();
    m_disp      = 0;
    cur_end     = -1000;
    pend_active = 1'b0;
    tick(n);
    sys_rst_n   = 1'b1;
  endtask

  // Monitor: snapshot inputs and model at each edge, compare DUT outputs at the next falling edge.
  initial begin
    int         s_slot;
    int         s_dig;
    int         s_disp;
    logic [5:0] s_pt;
    logic       s_sg;
    logic       s_en;
    bit         s_valid;
    bit         exp_busy;
    logic [5:0] exp_sel;
    logic [7:0] exp_seg;
    s_valid  = 1'b0;
    exp_busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      if (sys_rst_n) begin
        e++;
        s_valid = 1'b1;
        s_slot  = (e - 1) % SLOT;
        s_dig   = ((e - 1) / SLOT) % 6;
        s_pt    = bus.i_point;
        s_sg    = bus.i_sign;
        s_en    = bus.i_seg_en;
        s_disp  = m_disp;
        while (q.size() > 0 && q[0].t <= e) begin
          m_disp = q[0].v;
          void'(q.pop_front());
        end
        exp_busy = (q.size() > 0) && (e >= q[0].start);
      end else begin
        e       = 0;
        s_valid = 1'b0;
      end
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        check("reset_sel", 32'(bus.o_sel), 32'h00);
        check("reset_seg", 32'(bus.o_seg), 32'hFF);
        check("reset_busy", 32'(bus.o_busy), 32'h0);
      end else if (s_valid) begin
        exp_sel = s_en ? 6'(1 << s_dig) : 6'd0;
        if (!s_en || s_slot < BLANK_CYC) exp_seg = 8'hFF;
        else                             exp_seg = digit_code(s_disp, s_dig, s_pt, s_sg);
        check("busy", 32'(bus.o_busy), 32'(exp_busy));
        check("sel", 32'(bus.o_sel), 32'(exp_sel));
        check("seg", 32'(bus.o_seg), 32'(exp_seg));
      end
    end
  end

  initial begin
    int v;
    bus.i_data     = '0;
    bus.i_data_vld = 1'b0;
    bus.i_point    = '0;
    bus.i_sign     = 1'b0;
    bus.i_seg_en   = 1'b1;

    do_reset(3);
    tick(70);

    strobe(123456);
    tick(80);

    strobe(1_048_575);
    tick(80);

    bus.i_point = 6'b000100;
    bus.i_sign  = 1'b1;
    strobe(50);
    tick(80);
    bus.i_point = '0;
    bus.i_sign  = 1'b0;

    strobe(7);
    tick(2);
    strobe(999);
    tick(5);
    strobe(42);
    tick(90);

    strobe(11);
    tick(20);
    strobe(22);
    tick(80);

    bus.i_sign = 1'b1;
    tick(13);
    bus.i_seg_en = 1'b0;
    tick(25);
    bus.i_seg_en = 1'b1;
    tick(70);
    bus.i_sign = 1'b0;

    strobe(654321);
    tick(8);
    do_reset(2);
    tick(70);

    for (int it = 0; it < 40; it++) begin
      bus.i_point  = 6'($urandom_range(0, 63));
      bus.i_sign   = 1'($urandom_range(0, 1));
      bus.i_seg_en = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0:       v = int'($urandom_range(0, 99));
        1:       v = int'($urandom_range(0, 999_999));
        default: v = int'($urandom_range(0, 1_048_575));
      endcase
      strobe(v);
      tick(int'($urandom_range(0, 70)));
    end

    bus.i_seg_en = 1'b1;
    tick(100);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
